// File: rtl/b3_dec_pulse_if.sv
// ---------------------------------------------------------------------------
// b3_dec_pulse_if
// Handshake and output bundle for the b3_dec_pulse sequenced one-hot decoder.
//   enable      : block enable (upstream -> decoder)
//   binary_in   : 4-bit index to decode (upstream -> decoder)
//   in_valid    : binary_in valid this cycle (upstream -> decoder)
//   in_ready    : decoder can accept an index this cycle (decoder -> upstream)
//   decoder_out : registered one-hot select bus (decoder -> consumer)
//   out_active  : high while decoder_out is non-zero (decoder -> consumer)
//   done        : one-cycle pulse at normal end of a hold period
// master = upstream/consumer side, slave = decoder side.
// ---------------------------------------------------------------------------
interface b3_dec_pulse_if;
   logic        enable;
   logic [3:0]  binary_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] decoder_out;
   logic        out_active;
   logic        done;

   modport master (
      output enable, binary_in, in_valid,
      input  in_ready, decoder_out, out_active, done
   );

   modport slave (
      input  enable, binary_in, in_valid,
      output in_ready, decoder_out, out_active, done
   );
endinterface

// File: rtl/b3_dec_pulse.sv
// ---------------------------------------------------------------------------
// b3_dec_pulse
// Sequenced 4-to-16 one-hot decoder. An index accepted over a valid/ready
// handshake drives exactly one bit of decoder_out for HOLD_CYCLES cycles,
// after which the bus is released and done pulses for one cycle. Dropping
// enable during a hold aborts the pulse without a done pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : b3_dec_pulse_if.slave (enable, binary_in, in_valid, in_ready,
//           decoder_out, out_active, done)
// Parameters:
//   HOLD_CYCLES : cycles the one-hot output stays asserted (1..255)
//   CNT_W       : hold counter width, 2**CNT_W > HOLD_CYCLES
// ---------------------------------------------------------------------------
module b3_dec_pulse #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic           clk,
   input  logic           reset,
   b3_dec_pulse_if.slave  bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      dec_q;
   logic             active_q;
   logic             done_q;
   logic             accept;

   // Ready is combinational so a new index can be taken in the done cycle,
   // leaving exactly one all-zero cycle between consecutive pulses.
   assign bus.in_ready = (state == IDLE) && bus.enable && !reset;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dec_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= HOLD;
                  dec_q    <= 16'h0001 << bus.binary_in;
                  active_q <= 1'b1;
                  cnt      <= CNT_LOAD;
               end
            end
            HOLD: begin
               if (!bus.enable) begin
                  // Abort: release the bus silently; no resume on re-enable.
                  state    <= IDLE;
                  dec_q    <= '0;
                  active_q <= 1'b0;
                  cnt      <= '0;
               end else if (cnt == '0) begin
                  state    <= IDLE;
                  dec_q    <= '0;
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               dec_q    <= '0;
               active_q <= 1'b0;
               cnt      <= '0;
            end
         endcase
      end
   end

   assign bus.decoder_out = dec_q;
   assign bus.out_active  = active_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_b3_dec_pulse.sv
// ---------------------------------------------------------------------------
// tb_b3_dec_pulse
// Drives two decoders (HOLD_CYCLES=4 and HOLD_CYCLES=1) from one shared
// stimulus stream. The reference keeps, per decoder, a timeline of the value
// decoder_out must show in every future cycle and the cycles where done must
// pulse: an accept paints the next HOLD_CYCLES slots with the one-hot value
// and marks done right after them; an abort erases what was painted.
// ---------------------------------------------------------------------------
module tb_b3_dec_pulse;

   localparam int MAXC = 2000;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       in_valid;
   logic [3:0] binary_in;

   always #5 clk = ~clk;

   b3_dec_pulse_if if_a ();
   b3_dec_pulse_if if_b ();

   assign if_a.enable    = enable;
   assign if_a.in_valid  = in_valid;
   assign if_a.binary_in = binary_in;
   assign if_b.enable    = enable;
   assign if_b.in_valid  = in_valid;
   assign if_b.binary_in = binary_in;

   b3_dec_pulse #(.HOLD_CYCLES(4), .CNT_W(8)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   b3_dec_pulse #(.HOLD_CYCLES(1), .CNT_W(8)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   logic [15:0] dout [2];
   logic        act  [2];
   logic        dn   [2];
   logic        rdy  [2];

   assign dout[0] = if_a.decoder_out;
   assign dout[1] = if_b.decoder_out;
   assign act[0]  = if_a.out_active;
   assign act[1]  = if_b.out_active;
   assign dn[0]   = if_a.done;
   assign dn[1]   = if_b.done;
   assign rdy[0]  = if_a.in_ready;
   assign rdy[1]  = if_b.in_ready;

   bit [15:0] exp_out  [2][MAXC];
   bit        exp_done [2][MAXC];
   bit        acc      [2];
   bit        prev_done[2];
   int        done_cnt [2];
   int        cyc;
   int        n_chk;
   int        n_fail;

   function automatic int hold_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
      n_chk++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, actual, expected);
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("decoder_out%0d", k), 32'(dout[k]), 32'(exp_out[k][cyc]));
         check_val($sformatf("out_active%0d", k), 32'(act[k]), 32'(exp_out[k][cyc] != 16'h0));
         check_val($sformatf("done%0d", k), 32'(dn[k]), 32'(exp_done[k][cyc]));
         check_val($sformatf("onehot%0d", k), 32'($countones(dout[k]) <= 1), 32'(1));
         check_val($sformatf("done_vs_active%0d", k), 32'(dn[k] && act[k]), 32'(0));
         check_val($sformatf("done_twice%0d", k), 32'(dn[k] && prev_done[k]), 32'(0));
         prev_done[k] = dn[k];
         if (dn[k] === 1'b1) done_cnt[k]++;
      end
   endtask

   // One clock cycle: apply inputs at the falling edge, check in_ready,
   // update the reference timelines, then check outputs of the next cycle.
   task automatic step(input logic en, input logic v, input logic [3:0] idx);
      int h;
      bit r;
      enable    = en;
      in_valid  = v;
      binary_in = idx;
      #1;
      for (int k = 0; k < 2; k++) begin
         h = hold_of(k);
         r = en && !reset && (exp_out[k][cyc] == 16'h0);
         check_val($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(r));
         acc[k] = 1'b0;
         if (v && r) begin
            acc[k] = 1'b1;
            for (int j = 1; j <= h; j++) exp_out[k][cyc+j] = 16'h0001 << idx;
            exp_done[k][cyc+h+1] = 1'b1;
         end else if (!en && exp_out[k][cyc] != 16'h0) begin
            for (int j = 1; j <= h + 1; j++) begin
               exp_out[k][cyc+j]  = 16'h0;
               exp_done[k][cyc+j] = 1'b0;
            end
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("%s_out%0d", tag, k), 32'(dout[k]), 32'(0));
         check_val($sformatf("%s_active%0d", tag, k), 32'(act[k]), 32'(0));
         check_val($sformatf("%s_done%0d", tag, k), 32'(dn[k]), 32'(0));
         check_val($sformatf("%s_ready%0d", tag, k), 32'(rdy[k]), 32'(0));
      end
   endtask

   // Reset asserted between clock edges; outputs must clear without a clock.
   task automatic reset_mid_cycle();
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      for (int k = 0; k < 2; k++) begin
         for (int j = cyc; j < cyc + 300 && j < MAXC; j++) begin
            exp_out[k][j]  = 16'h0;
            exp_done[k][j] = 1'b0;
         end
         prev_done[k] = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all_zero("rst_held");
      reset = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0);
   endtask

   initial begin
      int tries;
      n_chk     = 0;
      n_fail    = 0;
      cyc       = 0;
      reset     = 1'b1;
      enable    = 1'b1;
      in_valid  = 1'b1;
      binary_in = 4'd3;
      for (int k = 0; k < 2; k++) begin
         prev_done[k] = 1'b0;
         done_cnt[k]  = 0;
      end

      // Reset state, with enable and valid already asserted.
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset    = 1'b0;
      in_valid = 1'b0;

      // Single index 5.
      step(1'b1, 1'b1, 4'd5);
      check_val("idx5_first", 32'(dout[0]), 32'h0020);
      drain(7);

      // All indices in order, valid held, advance only on acceptance.
      done_cnt[0] = 0;
      for (int i = 0; i < 16; i++) begin
         tries = 0;
         do begin
            step(1'b1, 1'b1, 4'(i));
            tries++;
         end while (!acc[0] && tries < 20);
         if (!acc[0]) check_val("sweep_accept_timeout", 32'(0), 32'(1));
      end
      drain(6);
      check_val("sweep_done_count", 32'(done_cnt[0]), 32'(16));

      // Back-to-back same index (single-cycle strobe on the HOLD_CYCLES=1 unit).
      repeat (4) step(1'b1, 1'b1, 4'd3);
      drain(6);

      // Abort: accept 15, drop enable in the second hold cycle.
      done_cnt[0] = 0;
      step(1'b1, 1'b1, 4'd15);
      check_val("idx15_first", 32'(dout[0]), 32'h8000);
      step(1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 4'd4);
      check_val("abort_cleared", 32'(dout[0]), 32'(0));
      repeat (3) step(1'b0, 1'b1, 4'd4);
      check_val("abort_no_done", 32'(done_cnt[0]), 32'(0));
      step(1'b1, 1'b1, 4'd4);
      check_val("after_abort", 32'(dout[0]), 32'h0010);
      drain(6);

      // Asynchronous reset in the middle of a hold of index 9.
      step(1'b1, 1'b1, 4'd9);
      step(1'b1, 1'b0, 4'd0);
      reset_mid_cycle();
      drain(4);

      // Index change during hold is ignored; 7 is taken in the done cycle.
      step(1'b1, 1'b1, 4'd2);
      check_val("idx2_first", 32'(dout[0]), 32'h0004);
      tries = 0;
      do begin
         step(1'b1, 1'b1, 4'd7);
         tries++;
      end while (!acc[0] && tries < 10);
      check_val("idx7_done_cycle_accept", 32'(dn[0]), 32'(0));
      if (!acc[0]) check_val("idx7_accept_timeout", 32'(0), 32'(1));
      step(1'b1, 1'b0, 4'd0);
      check_val("idx7_visible", 32'(dout[0]), 32'h0080);
      drain(6);

      // Random traffic with occasional enable drops and resets.
      for (int i = 0; i < 700 && cyc < MAXC - 20; i++) begin
         if ($urandom_range(0, 99) == 0) reset_mid_cycle();
         else step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)));
      end
      drain(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
